alu_exec_unit: RTL and testbench

//  MIPS execute-stage datapath slice: ALU-control decode, 32-bit ALU with zero flag, and PC adders.

---
 rtl/alu_exec_unit.sv | 190 +++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// MIPS execute-stage slice: ALU-control decode, 32-bit ALU with zero flag, PC+4 and branch-target adders.
// Latency: 1 clk; inputs sampled at a rising edge with en=1 appear on the registered outputs after that edge.
// Backpressure: none; en=0 stalls the stage and holds every output. Optional ALU_OVF_EN adds a registered ovf port.
module alu_exec_unit #(
   parameter int WIDTH   = 32,
   parameter int PC_STEP = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [1:0]       alu_op,
   input  logic [5:0]       func_code,
   input  logic [5:0]       opcode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] pc,
   input  logic [WIDTH-1:0] imm_ext,
   output logic [3:0]       alu_ctrl,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic [WIDTH-1:0] next_pc,
   output logic [WIDTH-1:0] branch_pc
`ifdef ALU_OVF_EN
   ,
   output logic             ovf
`endif
);

   // Control-unit ALU op classes.
   localparam logic [1:0] OP_ADD   = 2'b00;
   localparam logic [1:0] OP_SUB   = 2'b01;
   localparam logic [1:0] OP_RTYPE = 2'b10;
   localparam logic [1:0] OP_ITYPE = 2'b11;

   // R-type funct codes.
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_XOR = 6'b100110;
   localparam logic [5:0] FN_NOR = 6'b100111;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_SLL = 6'b000000;
   localparam logic [5:0] FN_SRL = 6'b000010;

   // I-type opcodes.
   localparam logic [5:0] OC_ADDI = 6'b001000;
   localparam logic [5:0] OC_ANDI = 6'b001100;
   localparam logic [5:0] OC_ORI  = 6'b001101;
   localparam logic [5:0] OC_XORI = 6'b001110;
   localparam logic [5:0] OC_SLTI = 6'b001010;
   localparam logic [5:0] OC_LUI  = 6'b001111;

   // Decoded ALU operations.
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_XOR = 4'b0011;
   localparam logic [3:0] ALU_SLL = 4'b0100;
   localparam logic [3:0] ALU_SRL = 4'b0101;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_LUI = 4'b1000;
   localparam logic [3:0] ALU_NOR = 4'b1100;
   localparam logic [3:0] ALU_NOP = 4'b1111;

   localparam int SHW  = $clog2(WIDTH);
   localparam int HALF = WIDTH / 2;

   logic [5:0]       sel;
   logic [3:0]       ctrl_nxt;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic             slt;
   logic [WIDTH-1:0] result_nxt;
   logic             zero_nxt;
   logic [WIDTH-1:0] next_pc_nxt;
   logic [WIDTH-1:0] branch_pc_nxt;

   // Decode op class plus funct/opcode into the 4-bit ALU operation; unknown codes become NOP.
   always_comb begin
      ctrl_nxt = ALU_NOP;
      sel      = (alu_op == OP_ITYPE) ? opcode : func_code;
      case (alu_op)
         OP_ADD: ctrl_nxt = ALU_ADD;
         OP_SUB: ctrl_nxt = ALU_SUB;
         OP_RTYPE: begin
            case (sel)
               FN_ADD:  ctrl_nxt = ALU_ADD;
               FN_SUB:  ctrl_nxt = ALU_SUB;
               FN_AND:  ctrl_nxt = ALU_AND;
               FN_OR:   ctrl_nxt = ALU_OR;
               FN_XOR:  ctrl_nxt = ALU_XOR;
               FN_NOR:  ctrl_nxt = ALU_NOR;
               FN_SLT:  ctrl_nxt = ALU_SLT;
               FN_SLL:  ctrl_nxt = ALU_SLL;
               FN_SRL:  ctrl_nxt = ALU_SRL;
               default: ctrl_nxt = ALU_NOP;
            endcase
         end
         OP_ITYPE: begin
            case (sel)
               OC_ADDI: ctrl_nxt = ALU_ADD;
               OC_ANDI: ctrl_nxt = ALU_AND;
               OC_ORI:  ctrl_nxt = ALU_OR;
               OC_XORI: ctrl_nxt = ALU_XOR;
               OC_SLTI: ctrl_nxt = ALU_SLT;
               OC_LUI:  ctrl_nxt = ALU_LUI;
               default: ctrl_nxt = ALU_NOP;
            endcase
         end
         default: ctrl_nxt = ALU_NOP;
      endcase
   end

   // Shared adder/subtractor and signed compare feeding the result mux.
   always_comb begin
      sum  = a + b;
      diff = a - b;
      slt  = ($signed(a) < $signed(b));
   end

   // ALU result select; shifts use only the low shift-amount bits of a, and zero is taken from the
   // selected result so NOP reports zero=1.
   always_comb begin
      result_nxt = '0;
      case (ctrl_nxt)
         ALU_AND: result_nxt = a & b;
         ALU_OR:  result_nxt = a | b;
         ALU_ADD: result_nxt = sum;
         ALU_XOR: result_nxt = a ^ b;
         ALU_SLL: result_nxt = b << a[SHW-1:0];
         ALU_SRL: result_nxt = b >> a[SHW-1:0];
         ALU_SUB: result_nxt = diff;
         ALU_SLT: result_nxt = {{(WIDTH-1){1'b0}}, slt};
         ALU_LUI: result_nxt = {b[HALF-1:0], {HALF{1'b0}}};
         ALU_NOR: result_nxt = ~(a | b);
         default: result_nxt = '0;
      endcase
      zero_nxt = (result_nxt == '0);
   end

   // Sequential PC and branch-target adders; both wrap modulo 2^WIDTH.
   always_comb begin
      next_pc_nxt   = pc + WIDTH'(PC_STEP);
      branch_pc_nxt = next_pc_nxt + {imm_ext[WIDTH-3:0], 2'b00};
   end

   // Output registers: reset dominates, en=0 holds.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alu_ctrl  <= 4'b0000;
         result    <= '0;
         zero      <= 1'b1;
         next_pc   <= '0;
         branch_pc <= '0;
      end else if (en) begin
         alu_ctrl  <= ctrl_nxt;
         result    <= result_nxt;
         zero      <= zero_nxt;
         next_pc   <= next_pc_nxt;
         branch_pc <= branch_pc_nxt;
      end
   end

`ifdef ALU_OVF_EN
   logic ovf_nxt;

   // Signed overflow: ADD when like-signed operands yield an opposite-signed sum, SUB when
   // operand signs differ and the difference takes b's sign; the result is still written.
   always_comb begin
      ovf_nxt = 1'b0;
      case (ctrl_nxt)
         ALU_ADD: ovf_nxt = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
         ALU_SUB: ovf_nxt = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         default: ovf_nxt = 1'b0;
      endcase
   end

   // Overflow flag register, same reset/hold behaviour as the other outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf <= 1'b0;
      end else if (en) begin
         ovf <= ovf_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: decode, ALU ops, PC adders, hold and async reset.
// Each stimulus is applied after a sample point and checked 1 time unit after the next rising edge.
// Build with ALU_OVF_EN defined to also exercise the overflow flag.
module tb_alu_exec_unit;

   logic        clk;
   logic        reset;
   logic        en;
   logic [1:0]  alu_op;
   logic [5:0]  func_code;
   logic [5:0]  opcode;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] pc;
   logic [31:0] imm_ext;
   logic [3:0]  alu_ctrl;
   logic [31:0] result;
   logic        zero;
   logic [31:0] next_pc;
   logic [31:0] branch_pc;
`ifdef ALU_OVF_EN
   logic        ovf;
`endif

   int total;
   int bad;

   alu_exec_unit #(.WIDTH(32), .PC_STEP(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .alu_op    (alu_op),
      .func_code (func_code),
      .opcode    (opcode),
      .a         (a),
      .b         (b),
      .pc        (pc),
      .imm_ext   (imm_ext),
      .alu_ctrl  (alu_ctrl),
      .result    (result),
      .zero      (zero),
      .next_pc   (next_pc),
      .branch_pc (branch_pc)
`ifdef ALU_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input logic [1:0] op, input logic [5:0] fc, input logic [5:0] oc,
                       input logic [31:0] ia, input logic [31:0] ib);
      alu_op = op; func_code = fc; opcode = oc; a = ia; b = ib; en = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; en = 1'b0; alu_op = 2'b00; func_code = 6'd0; opcode = 6'd0;
      a = 32'd0; b = 32'd0; pc = 32'd0; imm_ext = 32'd0;
      #2 reset = 1'b1;
      #1;
      total++;
      if ({alu_ctrl, result, zero, next_pc, branch_pc} !== {4'h0, 32'h0, 1'b1, 32'h0, 32'h0}) begin
         bad++;
         $display("FAIL reset_state: ctrl=%h result=%h zero=%b next_pc=%h branch_pc=%h want 0/0/1/0/0",
                  alu_ctrl, result, zero, next_pc, branch_pc);
      end
`ifdef ALU_OVF_EN
      total++;
      if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
`endif
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_add();
      pc = 32'h0000_0000; imm_ext = 32'd0;
      step(2'b00, 6'b111111, 6'b111111, 32'd5, 32'd7);
      total++;
      if ({alu_ctrl, result, zero} !== {4'b0010, 32'd12, 1'b0}) begin
         bad++;
         $display("FAIL add_basic: ctrl=%b result=%h zero=%b want 0010/0000000c/0", alu_ctrl, result, zero);
      end
      total++;
      if ({next_pc, branch_pc} !== {32'h4, 32'h4}) begin
         bad++;
         $display("FAIL add_pc: next_pc=%h branch_pc=%h want 4/4", next_pc, branch_pc);
      end
   endtask

   task automatic test_sub_branch();
      pc = 32'h0000_0100; imm_ext = 32'hFFFF_FFFF;
      step(2'b01, 6'b100000, 6'b001111, 32'h1234, 32'h1234);
      total++;
      if ({alu_ctrl, result, zero} !== {4'b0110, 32'h0, 1'b1}) begin
         bad++;
         $display("FAIL sub_equal: ctrl=%b result=%h zero=%b want 0110/00000000/1", alu_ctrl, result, zero);
      end
      total++;
      if ({next_pc, branch_pc} !== {32'h104, 32'h100}) begin
         bad++;
         $display("FAIL branch_back: next_pc=%h branch_pc=%h want 104/100", next_pc, branch_pc);
      end
   endtask

   task automatic test_rtype();
      logic [5:0]  fc [13] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111,
                               6'b101010, 6'b101010, 6'b000000, 6'b000000, 6'b000010, 6'b000010,
                               6'b111111};
      logic [31:0] va [13] = '{32'd1, 32'd3, 32'hF0, 32'hF0, 32'hFF, 32'd0,
                               32'hFFFF_FFFF, 32'd1, 32'd4, 32'h24, 32'd4, 32'd31,
                               32'd5};
      logic [31:0] vb [13] = '{32'd2, 32'd5, 32'h3C, 32'h0F, 32'h0F, 32'd0,
                               32'd1, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'h80, 32'h8000_0000,
                               32'd5};
      logic [31:0] er [13] = '{32'd3, 32'hFFFF_FFFE, 32'h30, 32'hFF, 32'hF0, 32'hFFFF_FFFF,
                               32'd1, 32'd0, 32'd16, 32'd16, 32'd8, 32'd1,
                               32'd0};
      logic [3:0]  ec [13] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0011, 4'b1100,
                               4'b0111, 4'b0111, 4'b0100, 4'b0100, 4'b0101, 4'b0101,
                               4'b1111};
      logic        ez [13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b1};
      for (int i = 0; i < 13; i++) begin
         // opcode deliberately looks like LUI to prove R-type ignores it
         step(2'b10, fc[i], 6'b001111, va[i], vb[i]);
         total++;
         if ({alu_ctrl, result, zero} !== {ec[i], er[i], ez[i]}) begin
            bad++;
            $display("FAIL rtype[%0d] funct=%b: ctrl=%b result=%h zero=%b want %b/%h/%b",
                     i, fc[i], alu_ctrl, result, zero, ec[i], er[i], ez[i]);
         end
      end
   endtask

   task automatic test_itype();
      logic [5:0]  oc [8] = '{6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010, 6'b001111,
                              6'b111111, 6'b000000};
      logic [31:0] va [8] = '{32'd10, 32'hFF, 32'hF0, 32'hFF, 32'hFFFF_FFFE, 32'h1234_5678,
                              32'd9, 32'd9};
      logic [31:0] vb [8] = '{32'hFFFF_FFFF, 32'h0F, 32'h0F, 32'hFF, 32'hFFFF_FFFF, 32'h0000_ABCD,
                              32'd9, 32'd1};
      logic [31:0] er [8] = '{32'd9, 32'h0F, 32'hFF, 32'h0, 32'd1, 32'hABCD_0000,
                              32'd0, 32'd0};
      logic [3:0]  ec [8] = '{4'b0010, 4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1000,
                              4'b1111, 4'b1111};
      logic        ez [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 8; i++) begin
         // func_code deliberately looks like ADD to prove I-type selects the opcode
         step(2'b11, 6'b100000, oc[i], va[i], vb[i]);
         total++;
         if ({alu_ctrl, result, zero} !== {ec[i], er[i], ez[i]}) begin
            bad++;
            $display("FAIL itype[%0d] opcode=%b: ctrl=%b result=%h zero=%b want %b/%h/%b",
                     i, oc[i], alu_ctrl, result, zero, ec[i], er[i], ez[i]);
         end
      end
   endtask

   task automatic test_wrap();
      pc = 32'hFFFF_FFFC; imm_ext = 32'd1;
      step(2'b00, 6'd0, 6'd0, 32'hFFFF_FFFF, 32'd1);
      total++;
      if ({result, zero} !== {32'h0, 1'b1}) begin
         bad++;
         $display("FAIL add_wrap: result=%h zero=%b want 00000000/1", result, zero);
      end
      total++;
      if ({next_pc, branch_pc} !== {32'h0, 32'h4}) begin
         bad++;
         $display("FAIL pc_wrap: next_pc=%h branch_pc=%h want 0/4", next_pc, branch_pc);
      end
   endtask

   task automatic test_hold();
      pc = 32'h200; imm_ext = 32'd2;
      step(2'b00, 6'd0, 6'd0, 32'd5, 32'd7);
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         alu_op = 2'(i + 1); func_code = 6'b100111; opcode = 6'b001111;
         a = 32'h1111_0000 * (i + 1); b = 32'hDEAD_0000 + i; pc = 32'h4000 + i; imm_ext = i;
         @(posedge clk);
         #1;
         total++;
         if ({alu_ctrl, result, zero, next_pc, branch_pc} !== {4'b0010, 32'd12, 1'b0, 32'h204, 32'h20C}) begin
            bad++;
            $display("FAIL hold[%0d]: ctrl=%b result=%h zero=%b next_pc=%h branch_pc=%h want 0010/c/0/204/20c",
                     i, alu_ctrl, result, zero, next_pc, branch_pc);
         end
      end
      pc = 32'h300; imm_ext = 32'd0;
      step(2'b10, 6'b100101, 6'd0, 32'hA0, 32'h05);
      total++;
      if ({alu_ctrl, result, next_pc} !== {4'b0001, 32'hA5, 32'h304}) begin
         bad++;
         $display("FAIL resume: ctrl=%b result=%h next_pc=%h want 0001/a5/304", alu_ctrl, result, next_pc);
      end
   endtask

   task automatic test_async_reset();
      pc = 32'h500; imm_ext = 32'd4;
      step(2'b10, 6'b100111, 6'd0, 32'd0, 32'd0);
      #2 reset = 1'b1;
      #1;
      total++;
      if ({alu_ctrl, result, zero, next_pc, branch_pc} !== {4'h0, 32'h0, 1'b1, 32'h0, 32'h0}) begin
         bad++;
         $display("FAIL async_clear: ctrl=%b result=%h zero=%b next_pc=%h branch_pc=%h want 0/0/1/0/0",
                  alu_ctrl, result, zero, next_pc, branch_pc);
      end
      en = 1'b1; alu_op = 2'b00; a = 32'd1; b = 32'd2;
      @(posedge clk);
      #1;
      total++;
      if ({alu_ctrl, result, zero, next_pc} !== {4'h0, 32'h0, 1'b1, 32'h0}) begin
         bad++;
         $display("FAIL reset_dominates: ctrl=%b result=%h zero=%b next_pc=%h want 0/0/1/0",
                  alu_ctrl, result, zero, next_pc);
      end
      reset = 1'b0;
      step(2'b00, 6'd0, 6'd0, 32'd1, 32'd2);
      total++;
      if ({alu_ctrl, result, zero, next_pc, branch_pc} !== {4'b0010, 32'd3, 1'b0, 32'h504, 32'h514}) begin
         bad++;
         $display("FAIL after_release: ctrl=%b result=%h zero=%b next_pc=%h branch_pc=%h want 0010/3/0/504/514",
                  alu_ctrl, result, zero, next_pc, branch_pc);
      end
   endtask

`ifdef ALU_OVF_EN
   task automatic test_ovf();
      logic [1:0]  op [5] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b00};
      logic [5:0]  fc [5] = '{6'd0, 6'd0, 6'd0, 6'b100100, 6'd0};
      logic [31:0] va [5] = '{32'h7FFF_FFFF, 32'd0, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000};
      logic [31:0] vb [5] = '{32'd1, 32'd1, 32'd1, 32'd1, 32'h8000_0000};
      logic [31:0] er [5] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd1, 32'd0};
      logic        eo [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 5; i++) begin
         step(op[i], fc[i], 6'd0, va[i], vb[i]);
         total++;
         if ({result, ovf} !== {er[i], eo[i]}) begin
            bad++;
            $display("FAIL ovf[%0d]: result=%h ovf=%b want %h/%b", i, result, ovf, er[i], eo[i]);
         end
      end
   endtask
`endif

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_add();
      test_sub_branch();
      test_rtype();
      test_itype();
      test_wrap();
      test_hold();
      test_async_reset();
`ifdef ALU_OVF_EN
      test_ovf();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
